// File: rtl/seg_shift_ctrl.sv
// seg_shift_ctrl
//   Moves the 64-bit seven-segment pattern onto a chain of 8 daisy-chained
//   8-bit shift registers. A transfer is requested by start, by a latched
//   pending request, or by the periodic refresh tick. The pattern is snapshotted
//   at acceptance and shifted out MSB-first on a divided serial clock. After
//   the last bit, the chain is given a latch phase. The block also produces the
//   free-running blink enable for the segment encoder.
//
//   Optional feature macro: SEG_AUTO_REFRESH_EN
//     defined   - refresh counter compiled in; a transfer starts every REFRESH
//                 cycles.
//     undefined - no refresh counter; transfers start only from start.
//
// Parameters
//   DIV        seg_clk half-period in clk cycles (>= 1)
//   REFRESH    auto-refresh period in clk cycles (>= 129*DIV+2)
//   FLASH_BITS blink counter width; flash period is 2^FLASH_BITS cycles
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   transfer request, sampled every cycle
//   seg_txt  in   segment pattern; [63:56] -> digit 0 ... [7:0] -> digit 7
//   busy     out  transfer in progress (SHIFT or LATCH)
//   done     out  one-cycle pulse in the first IDLE cycle after LATCH
//   flash    out  blink enable to the encoder
//   seg_clk  out  serial shift clock, chain samples on its rising edge
//   seg_sout out  serial data, MSB first
//   seg_pen  out  chain output enable, low while a transfer is in flight
//   seg_clrn out  chain clear, active-low, released on first clk after reset
module seg_shift_ctrl #(
  parameter int unsigned DIV        = 2,
  parameter int unsigned REFRESH    = 1000000,
  parameter int unsigned FLASH_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] seg_txt,
  output logic        busy,
  output logic        done,
  output logic        flash,
  output logic        seg_clk,
  output logic        seg_sout,
  output logic        seg_pen,
  output logic        seg_clrn
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  // One counter serves as the shift phase (0..2*DIV-1) and the latch timer
  // (0..DIV-1).
  localparam int unsigned PW = $clog2(2 * DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * DIV - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(DIV);
  localparam logic [PW-1:0] LT_LAST = PW'(DIV - 1);

  if (DIV == 0 || REFRESH < 129 * DIV + 2) begin : g_param_check
    $error("seg_shift_ctrl: DIV must be >= 1 and REFRESH >= 129*DIV+2");
  end

  state_t            state;
  logic [63:0]       sreg;
  logic [5:0]        bit_cnt;
  logic [PW-1:0]     phase;
  logic [PW-1:0]     phase_nx;
  logic              pending;
  logic              tick;
  logic [FLASH_BITS-1:0] flash_cnt;

  assign phase_nx = phase + PW'(1);
  assign seg_sout = sreg[63];
  assign flash    = ~flash_cnt[FLASH_BITS-1];

`ifdef SEG_AUTO_REFRESH_EN
  localparam int unsigned RW = $clog2(REFRESH);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH - 1);

  logic [RW-1:0] ref_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
    end else if (ref_cnt == RF_LAST) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  assign tick = (ref_cnt == RF_LAST);
`else
  assign tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt <= '0;
      seg_clrn  <= 1'b0;
    end else begin
      flash_cnt <= flash_cnt + FLASH_BITS'(1);
      seg_clrn  <= 1'b1;
    end
  end

  // Outputs busy/seg_clk/seg_pen/done are registered alongside the state, so
  // each transition assigns the level the outputs must hold in the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_clk <= 1'b1;
      seg_pen <= 1'b1;
    end else begin
      done <= 1'b0;
      // Any number of requests during a transfer collapse into one.
      if (state != IDLE && (start || tick)) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start || pending || tick) begin
            sreg    <= seg_txt;
            pending <= 1'b0;
            bit_cnt <= '0;
            phase   <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
            seg_clk <= 1'b0;
            seg_pen <= 1'b0;
          end
        end
        SHIFT: begin
          if (phase == PH_LAST) begin
            sreg    <= {sreg[62:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
            phase   <= '0;
            if (bit_cnt == 6'd63) begin
              state   <= LATCH;
              seg_clk <= 1'b1;
            end else begin
              seg_clk <= 1'b0;
            end
          end else begin
            phase   <= phase_nx;
            seg_clk <= (phase_nx >= PH_HI);
          end
        end
        LATCH: begin
          if (phase == LT_LAST) begin
            state   <= IDLE;
            phase   <= '0;
            busy    <= 1'b0;
            seg_pen <= 1'b1;
            done    <= 1'b1;
          end else begin
            phase <= phase_nx;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
module tb_seg_shift_ctrl;

  localparam int unsigned DIV     = 2;
  localparam int unsigned REFRESH = 300;
  localparam int unsigned FB      = 4;
  localparam int unsigned XFER    = 129 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] seg_txt = '0;
  logic        busy, done, flash, seg_clk, seg_sout, seg_pen, seg_clrn;

  int total = 0;
  int bad   = 0;

  seg_shift_ctrl #(.DIV(DIV), .REFRESH(REFRESH), .FLASH_BITS(FB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seg_txt  (seg_txt),
    .busy     (busy),
    .done     (done),
    .flash    (flash),
    .seg_clk  (seg_clk),
    .seg_sout (seg_sout),
    .seg_pen  (seg_pen),
    .seg_clrn (seg_clrn)
  );

  always #5 clk = ~clk;

  // Observer: samples once per cycle on the falling edge.
  logic [63:0] cap = '0;
  int unsigned nbits = 0, busy_cyc = 0, pen_low = 0, done_n = 0, rises = 0;
  logic prev_clk = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (busy && seg_clk && !prev_clk) begin
      cap   <= {cap[62:0], seg_sout};
      nbits <= nbits + 1;
    end
    prev_clk  <= seg_clk;
    prev_busy <= busy;
    if (busy)            busy_cyc <= busy_cyc + 1;
    if (!seg_pen)        pen_low  <= pen_low + 1;
    if (done)            done_n   <= done_n + 1;
    if (busy && !prev_busy) rises <= rises + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, seen, 1);
  endtask

  int unsigned n0, b0, p0, d0, r0;

  task automatic snap();
    n0 = nbits; b0 = busy_cyc; p0 = pen_low; d0 = done_n; r0 = rises;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full transfer of data; optionally overwrite seg_txt mid-flight.
  task automatic run_xfer(input string tag, input logic [63:0] data, input bit overwrite);
    seg_txt = data;
    snap();
    pulse_start();
    check({tag, "_busy_rise"}, busy, 1);
    check({tag, "_clk_low"}, seg_clk, 0);
    check({tag, "_first_bit"}, seg_sout, data[63]);
    repeat (DIV) @(negedge clk);
    check({tag, "_first_rise"}, seg_clk, 1);
    if (overwrite) begin
      repeat (10 - DIV) @(negedge clk);
      seg_txt = '1;
    end
    wait_done({tag, "_done_seen"});
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
    check({tag, "_stream"}, cap, data);
    check({tag, "_nbits"}, nbits - n0, 64);
    check({tag, "_busy_len"}, busy_cyc - b0, XFER);
    check({tag, "_pen_len"}, pen_low - p0, XFER);
    check({tag, "_done_cnt"}, done_n - d0, 1);
    check({tag, "_xfers"}, rises - r0, 1);
  endtask

  logic [31:0]   flash_obs, flash_exp;
  int unsigned   rise_q[$];
  logic          pb;
  logic [63:0]   da, dbv;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seg_clk", seg_clk, 1);
    check("rst_seg_sout", seg_sout, 0);
    check("rst_seg_pen", seg_pen, 1);
    check("rst_seg_clrn", seg_clrn, 0);
    check("rst_flash", flash, 1);

    // Release reset; k counts clk edges since release.
    rst = 1'b0;
    pb  = 1'b0;
    for (int unsigned k = 0; k < 2000; k++) begin
      if (k < 32) begin
        flash_obs[k] = flash;
        flash_exp[k] = ((k / 8) % 2) == 0;
      end
      if (k == 1) check("clrn_release", seg_clrn, 1);
      if (busy && !pb) rise_q.push_back(k);
      pb = busy;
      @(negedge clk);
    end
    check("flash_pattern", flash_obs, flash_exp);

`ifdef SEG_AUTO_REFRESH_EN
    check("refresh_count", rise_q.size(), 2000 / REFRESH);
    foreach (rise_q[i]) check($sformatf("refresh_at_%0d", i), rise_q[i], (i + 1) * REFRESH);
`else
    check("no_refresh", rise_q.size(), 0);

    run_xfer("basic", 64'h0123_4567_89AB_CDEF, 1'b0);
    run_xfer("snapshot", 64'h0123_4567_89AB_CDEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_xfer($sformatf("rand%0d", i), {$urandom, $urandom}, (i % 2) == 1);
    end

    // Pending: three requests during one transfer yield exactly one more.
    da  = {$urandom, $urandom};
    dbv = {$urandom, $urandom};
    seg_txt = da;
    snap();
    pulse_start();
    for (int j = 0; j < 3; j++) begin
      repeat ($urandom_range(20, 60)) @(negedge clk);
      pulse_start();
    end
    seg_txt = dbv;
    wait_done("pend_done1");
    check("pend_idle_at_done", busy, 0);
    check("pend_stream1", cap, da);
    @(negedge clk);
    check("pend_busy_after_done", busy, 1);
    wait_done("pend_done2");
    @(negedge clk);
    check("pend_stream2", cap, dbv);
    check("pend_done_cnt", done_n - d0, 2);
    check("pend_busy_len", busy_cyc - b0, 2 * XFER);
    repeat (400) @(negedge clk);
    check("pend_xfers", rises - r0, 2);

    // Reset mid-transfer with a request already pending.
    seg_txt = {$urandom, $urandom};
    snap();
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 1000; i++) begin
      if (nbits - n0 >= 30) break;
      @(negedge clk);
    end
    check("mid_bits_reached", (nbits - n0 >= 30), 1);
    #1 rst = 1'b1;
    #1;
    check("mid_clrn", seg_clrn, 0);
    check("mid_seg_clk", seg_clk, 1);
    check("mid_seg_pen", seg_pen, 1);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (600) @(negedge clk);
    check("mid_no_done", done_n - d0, 0);
    check("mid_no_xfer", rises - r0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
